chargen_bram_port_a_ctrl: RTL and testbench
===========================================

// Module: chargen_bram_port_a_ctrl
// PURPOSE
//  Owns port A of the chargen dual-port BRAM (read latency 1, per-column write enables).
//  Shares port A between two requesters: an APB slave (CPU access) and a hardware
//  clear engine that fills every word with a value.
//  Port B (VGA scan-out) is untouched by this block.
// PARAMETERS
//  COL_WIDTH      8   bits per byte-lane column; DATA_WIDTH = NUM_COLS*COL_WIDTH
//  NUM_COLS       4   columns per word; must be a power of 2; one PSTRB bit per column
//  ADDR_WIDTH     4   BRAM word-address width; DEPTH_WORDS = 2**ADDR_WIDTH
//  APB_ADDR_WIDTH 32  APB byte-address width; OFFS = log2(NUM_COLS)
// PORTS
//  clk_i          in   1               single clock (APB and BRAM port A)
//  arst_ni        in   1               asynchronous active-low reset
//  psel_i         in   1               APB select
//  penable_i      in   1               APB enable (access phase)
//  pwrite_i       in   1               APB write=1 / read=0
//  paddr_i        in   APB_ADDR_WIDTH  APB byte address
//  pwdata_i       in   DATA_WIDTH      APB write data
//  pstrb_i        in   NUM_COLS        APB byte-lane strobes
//  pready_o       out  1               APB ready
//  prdata_o       out  DATA_WIDTH      APB read data
//  pslverr_o      out  1               APB error (address out of range)
//  clear_start_i  in   1               one-cycle pulse: start fill of whole BRAM
//  clear_data_i   in   DATA_WIDTH      fill value, sampled on accepted clear_start_i
//  clear_busy_o   out  1               fill in progress
//  clear_done_o   out  1               one-cycle pulse after the last fill write
//  bram_addr_o    out  ADDR_WIDTH      to BRAM addra
//  bram_we_o      out  NUM_COLS        to BRAM wea
//  bram_din_o     out  DATA_WIDTH      to BRAM dina
//  bram_dout_i    in   DATA_WIDTH      from BRAM douta (valid 1 cycle after address)
// BEHAVIOUR
//  Reset (async, arst_ni=0): state IDLE; pready_o, pslverr_o, clear_busy_o, clear_done_o,
//   bram_we_o = 0; prdata_o = 0; bram_addr_o = 0; fill counter = 0; pending clear = 0.
//  Word index = paddr_i[OFFS+ADDR_WIDTH-1:OFFS]; paddr_i[OFFS-1:0] ignored.
//   Out of range: any paddr_i bit above OFFS+ADDR_WIDTH-1 set.
//  States: IDLE, RD_DATA, CLEAR. bram_we_o is 0 in every state/cycle not listed below.
//  IDLE, no clear request, psel_i&penable_i (first access cycle):
//   - out of range: pready_o=1, pslverr_o=1, bram_we_o=0, prdata_o=0 (zero wait).
//   - write: bram_addr_o=index, bram_we_o=pstrb_i, bram_din_o=pwdata_i;
//     pready_o=1 in the same cycle (zero wait); stay IDLE.
//   - read: bram_addr_o=index, pready_o=0 -> RD_DATA.
//  RD_DATA: pready_o=1, prdata_o=bram_dout_i, pslverr_o=0 -> IDLE (one wait state).
//  prdata_o is 0 whenever pready_o=0 or the transfer is a write.
//  Clear request = clear_start_i, or a pending clear latched while in RD_DATA.
//   - IDLE + clear request: capture clear_data_i; fill counter=0; clear_busy_o=1 -> CLEAR.
//     Wins over an APB access in the same cycle; that access then sees pready_o=0.
//   - clear_start_i in RD_DATA: latch as pending; the read completes normally;
//     CLEAR is entered from the following IDLE cycle.
//  CLEAR: each cycle bram_addr_o=counter, bram_we_o='1, bram_din_o=captured value;
//   counter+1. pready_o=0 throughout, so APB stalls.
//   - After the write at counter=DEPTH_WORDS-1: clear_done_o=1 for 1 cycle,
//     clear_busy_o=0 -> IDLE.
//   - Exactly DEPTH_WORDS write cycles; the counter does not wrap into a second pass.
//  clear_start_i while clear_busy_o=1 or while a clear is already pending: ignored.
//  APB transfer held across a clear: serviced from IDLE after the fill, normal timing.
//  Reset mid-operation (clear or read): everything returns to reset values immediately.
//   No further writes are issued; memory keeps any partial fill.
// TESTING (defaults: 16 words, valid byte addresses 0x00-0x3C)
//  1. APB write 0xA5A5_1234 @0x08 strb=0xF, then read @0x08 -> write pready in 1st
//     access cycle; read pready after 1 wait state; prdata=0xA5A5_1234; pslverr=0.
//  2. Write 0xFFFF_FFFF @0x0C, then write 0x0000_0000 strb=0x5, read @0x0C
//     -> 0xFF00_FF00.
//  3. Read and write @0x40 -> pslverr=1, pready=1 zero wait, no bram_we_o, prdata=0;
//     word 0 unchanged.
//  4. clear_start with clear_data=0x2020_2020 -> busy for exactly 16 cycles; addresses
//     0..15 written; done pulses once. Read of any word returns 0x2020_2020.
//  5. clear_start in the same cycle as an APB access; clear_start again while busy
//     -> APB pready held low 16 cycles then completes; second pulse ignored (one done).
//  6. arst_ni low after 5 fill writes -> outputs at reset values in same cycle;
//     words 0-4 filled, 5-15 keep prior contents; no done pulse.

Source files
------------

// File: rtl/chargen_bram_port_a_ctrl_if.sv
// APB slave bundle for the chargen BRAM port-A controller.
// Signal names keep the slave-side direction affixes of the block's port list.
interface chargen_bram_port_a_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_COLS       = 4
);
  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [DATA_WIDTH-1:0]     pwdata_i;
  logic [NUM_COLS-1:0]       pstrb_i;
  logic                      pready_o;
  logic [DATA_WIDTH-1:0]     prdata_o;
  logic                      pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/chargen_bram_port_a_ctrl.sv
// Arbitrates chargen BRAM port A between APB CPU access and a whole-memory fill engine.
// Fill wins over APB; a fill request arriving during a read wait state is held until IDLE.
module chargen_bram_port_a_ctrl #(
  parameter  int COL_WIDTH      = 8,
  parameter  int NUM_COLS       = 4,
  parameter  int ADDR_WIDTH     = 4,
  parameter  int APB_ADDR_WIDTH = 32,
  localparam int DATA_WIDTH     = NUM_COLS * COL_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  chargen_bram_port_a_ctrl_if.slave         apb,
  input  logic                              clear_start_i,
  input  logic [DATA_WIDTH-1:0]             clear_data_i,
  output logic                              clear_busy_o,
  output logic                              clear_done_o,
  output logic [ADDR_WIDTH-1:0]             bram_addr_o,
  output logic [NUM_COLS-1:0]               bram_we_o,
  output logic [DATA_WIDTH-1:0]             bram_din_o,
  input  logic [DATA_WIDTH-1:0]             bram_dout_i
);

  localparam int OFFS = $clog2(NUM_COLS);

  typedef enum logic [1:0] {IDLE, RD_DATA, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   fill_q, fill_d;
  logic                    pend_q, pend_d;
  logic                    done_q, done_d;

  logic [APB_ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0]     word_idx;
  logic                      out_of_range;
  logic                      apb_access;

  assign word_addr    = apb.paddr_i >> OFFS;
  assign word_idx     = word_addr[ADDR_WIDTH-1:0];
  assign out_of_range = (word_addr >> ADDR_WIDTH) != '0;
  assign apb_access   = apb.psel_i & apb.penable_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Fill value is pure data; it is only meaningful while a fill is pending or running.
  always_ff @(posedge clk_i) begin
    fill_q <= fill_d;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_d        = fill_q;
    pend_d        = pend_q;
    done_d        = 1'b0;
    apb.pready_o  = 1'b0;
    apb.pslverr_o = 1'b0;
    apb.prdata_o  = '0;
    bram_addr_o   = '0;
    bram_we_o     = '0;
    bram_din_o    = '0;

    case (state_q)
      IDLE: begin
        if (clear_start_i || pend_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
          if (!pend_q) fill_d = clear_data_i;
        end else if (apb_access) begin
          if (out_of_range) begin
            apb.pready_o  = 1'b1;
            apb.pslverr_o = 1'b1;
          end else if (apb.pwrite_i) begin
            bram_addr_o  = word_idx;
            bram_we_o    = apb.pstrb_i;
            bram_din_o   = apb.pwdata_i;
            apb.pready_o = 1'b1;
          end else begin
            bram_addr_o = word_idx;
            state_d     = RD_DATA;
          end
        end
      end
      RD_DATA: begin
        apb.pready_o = 1'b1;
        apb.prdata_o = bram_dout_i;
        state_d      = IDLE;
        if (clear_start_i && !pend_q) begin
          pend_d = 1'b1;
          fill_d = clear_data_i;
        end
      end
      CLEAR: begin
        bram_addr_o = cnt_q;
        bram_we_o   = '1;
        bram_din_o  = fill_q;
        cnt_d       = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset must silence the combinational port-A drive in the very cycle it asserts.
    if (!arst_ni) begin
      apb.pready_o  = 1'b0;
      apb.pslverr_o = 1'b0;
      apb.prdata_o  = '0;
      bram_addr_o   = '0;
      bram_we_o     = '0;
      bram_din_o    = '0;
    end
  end

  assign clear_busy_o = (state_q == CLEAR);
  assign clear_done_o = done_q;

endmodule

// File: tb/tb_chargen_bram_port_a_ctrl.sv
// Self-checking bench: BRAM behavioural model, transaction-level reference and per-cycle compare.
module tb_chargen_bram_port_a_ctrl;
  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        clear_start_i = 1'b0;
  logic [31:0] clear_data_i = '0;
  logic        clear_busy_o, clear_done_o;
  logic [3:0]  bram_addr_o;
  logic [3:0]  bram_we_o;
  logic [31:0] bram_din_o;
  logic [31:0] bram_dout_i;

  chargen_bram_port_a_ctrl_if #(.APB_ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_COLS(4)) apb_if ();

  chargen_bram_port_a_ctrl dut (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .apb           (apb_if),
    .clear_start_i (clear_start_i),
    .clear_data_i  (clear_data_i),
    .clear_busy_o  (clear_busy_o),
    .clear_done_o  (clear_done_o),
    .bram_addr_o   (bram_addr_o),
    .bram_we_o     (bram_we_o),
    .bram_din_o    (bram_din_o),
    .bram_dout_i   (bram_dout_i)
  );

  always #5 clk_i = ~clk_i;

  // Port-A BRAM: byte-lane writes, read latency 1, contents survive reset.
  logic [31:0] bram [DEPTH];
  always @(posedge clk_i) begin
    for (int l = 0; l < 4; l++)
      if (bram_we_o[l]) bram[bram_addr_o][l*8 +: 8] <= bram_din_o[l*8 +: 8];
    bram_dout_i <= bram[bram_addr_o];
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what port A must do, stated as remaining fill writes,
  // an outstanding read, a held fill request and the expected memory image.
  logic [31:0] exp_mem [DEPTH];
  int          m_left = 0;
  logic [31:0] m_val = '0;
  logic        m_rd = 1'b0;
  int          m_rd_idx = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_val = '0;
  logic        m_done = 1'b0;
  logic        mon_en = 1'b0;

  logic        e_rdy, e_err, e_busy, e_done, e_chk_addr, acc, oor;
  logic [3:0]  e_we;
  logic [31:0] e_prd, e_din, e_addr;
  int          idx;

  always @(negedge clk_i) begin
    if (mon_en) begin
      acc = apb_if.psel_i & apb_if.penable_i;
      oor = (apb_if.paddr_i >> 6) != 0;
      idx = int'((apb_if.paddr_i >> 2) & 32'hF);
      e_rdy = 0; e_err = 0; e_busy = 0; e_done = 0; e_chk_addr = 1;
      e_we = 0; e_prd = 0; e_din = 0; e_addr = 0;
      if (arst_ni) begin
        e_busy = (m_left > 0);
        e_done = m_done;
        e_chk_addr = 0;
        if (m_left > 0) begin
          e_we = 4'hF; e_addr = 32'(DEPTH - m_left); e_din = m_val; e_chk_addr = 1;
        end else if (m_rd) begin
          e_rdy = 1; e_prd = exp_mem[m_rd_idx];
        end else if (clear_start_i || m_pend) begin
          e_rdy = 0;
        end else if (acc) begin
          if (oor) begin
            e_rdy = 1; e_err = 1;
          end else if (apb_if.pwrite_i) begin
            e_rdy = 1; e_we = apb_if.pstrb_i; e_din = apb_if.pwdata_i;
            e_addr = 32'(idx); e_chk_addr = 1;
          end else begin
            e_addr = 32'(idx); e_chk_addr = 1;
          end
        end
      end
      chk("bram_we", 32'(bram_we_o), 32'(e_we));
      chk("pready", 32'(apb_if.pready_o), 32'(e_rdy));
      chk("pslverr", 32'(apb_if.pslverr_o), 32'(e_err));
      chk("prdata", apb_if.prdata_o, e_prd);
      chk("clear_busy", 32'(clear_busy_o), 32'(e_busy));
      chk("clear_done", 32'(clear_done_o), 32'(e_done));
      if (e_chk_addr) chk("bram_addr", 32'(bram_addr_o), e_addr);
      if (e_we != 0) chk("bram_din", bram_din_o, e_din);
      if (clear_done_o) done_cnt++;

      // advance the model to the next cycle
      if (!arst_ni) begin
        m_left = 0; m_rd = 0; m_pend = 0; m_done = 0;
      end else begin
        m_done = 0;
        if (m_left > 0) begin
          exp_mem[DEPTH - m_left] = m_val;
          m_left--;
          if (m_left == 0) m_done = 1;
        end else if (m_rd) begin
          m_rd = 0;
          if (clear_start_i && !m_pend) begin m_pend = 1; m_pend_val = clear_data_i; end
        end else if (clear_start_i || m_pend) begin
          m_left = DEPTH;
          m_val  = m_pend ? m_pend_val : clear_data_i;
          m_pend = 0;
        end else if (acc && !oor) begin
          if (apb_if.pwrite_i) begin
            for (int l = 0; l < 4; l++)
              if (apb_if.pstrb_i[l]) exp_mem[idx][l*8 +: 8] = apb_if.pwdata_i[l*8 +: 8];
          end else begin
            m_rd = 1; m_rd_idx = idx;
          end
        end
      end
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output logic [31:0] rdata,
                     output logic err, output int waits);
    int n = 0;
    @(posedge clk_i); #1;
    apb_if.psel_i = 1; apb_if.penable_i = 0; apb_if.pwrite_i = wr;
    apb_if.paddr_i = addr; apb_if.pwdata_i = data; apb_if.pstrb_i = strb;
    @(posedge clk_i); #1;
    apb_if.penable_i = 1;
    forever begin
      @(negedge clk_i);
      if (apb_if.pready_o) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL apb_timeout actual=no_pready expected=pready addr=%h", addr);
        break;
      end
    end
    rdata = apb_if.prdata_o; err = apb_if.pslverr_o; waits = n;
    @(posedge clk_i); #1;
    apb_if.psel_i = 0; apb_if.penable_i = 0;
  endtask

  task automatic pulse_clear(input logic [31:0] val);
    @(posedge clk_i); #1;
    clear_start_i = 1; clear_data_i = val;
    @(posedge clk_i); #1;
    clear_start_i = 0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          ws, busy_n, d0;

  initial begin
    apb_if.psel_i = 1; apb_if.penable_i = 1; apb_if.pwrite_i = 1;
    apb_if.paddr_i = 0; apb_if.pwdata_i = 32'hFFFF_FFFF; apb_if.pstrb_i = 4'hF;
    for (int i = 0; i < DEPTH; i++) begin bram[i] = 32'h0; exp_mem[i] = 32'h0; end
    #2 mon_en = 1;
    // reset state with an access held on the bus
    repeat (3) @(negedge clk_i);
    chk("rst_pready", 32'(apb_if.pready_o), 32'h0);
    chk("rst_we", 32'(bram_we_o), 32'h0);
    chk("rst_busy", 32'(clear_busy_o), 32'h0);
    chk("rst_addr", 32'(bram_addr_o), 32'h0);
    apb_if.psel_i = 0; apb_if.penable_i = 0;
    @(posedge clk_i); #1 arst_ni = 1;

    // 1: write then read back
    apb(1, 32'h08, 32'hA5A5_1234, 4'hF, rd, er, ws);
    chk("t1_wr_waits", 32'(ws), 32'd0);
    apb(0, 32'h08, 32'h0, 4'h0, rd, er, ws);
    chk("t1_rd_waits", 32'(ws), 32'd1);
    chk("t1_rdata", rd, 32'hA5A5_1234);
    chk("t1_err", 32'(er), 32'h0);

    // 2: partial strobes
    apb(1, 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, er, ws);
    apb(1, 32'h0D, 32'h0000_0000, 4'h5, rd, er, ws);
    apb(0, 32'h0C, 32'h0, 4'h0, rd, er, ws);
    chk("t2_rdata", rd, 32'hFF00_FF00);

    // 3: out-of-range accesses leave memory alone
    apb(1, 32'h00, 32'h0123_4567, 4'hF, rd, er, ws);
    apb(0, 32'h40, 32'h0, 4'h0, rd, er, ws);
    chk("t3_rd_err", 32'(er), 32'h1);
    chk("t3_rd_waits", 32'(ws), 32'd0);
    chk("t3_rd_data", rd, 32'h0);
    apb(1, 32'h40, 32'hDEAD_DEAD, 4'hF, rd, er, ws);
    chk("t3_wr_err", 32'(er), 32'h1);
    chk("t3_wr_waits", 32'(ws), 32'd0);
    chk("t3_word0", bram[0], 32'h0123_4567);

    // 4: full fill
    d0 = done_cnt; busy_n = 0;
    pulse_clear(32'h2020_2020);
    repeat (40) begin @(negedge clk_i); if (clear_busy_o) busy_n++; end
    chk("t4_busy_cycles", 32'(busy_n), 32'd16);
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
    apb(0, 32'h2C, 32'h0, 4'h0, rd, er, ws);
    chk("t4_rdata", rd, 32'h2020_2020);

    // 5: fill collides with an APB write; a second start during the fill is dropped
    d0 = done_cnt;
    fork
      apb(1, 32'h04, 32'h1357_9BDF, 4'hF, rd, er, ws);
      begin
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        clear_start_i = 1; clear_data_i = 32'h5A5A_5A5A;
        @(posedge clk_i); #1;
        clear_start_i = 0;
        repeat (3) @(posedge clk_i); #1;
        clear_start_i = 1; clear_data_i = 32'h7777_7777;
        @(posedge clk_i); #1;
        clear_start_i = 0;
      end
    join
    // one capture cycle plus the 16 fill cycles before the write is taken
    chk("t5_wr_waits", 32'(ws), 32'd17);
    repeat (30) @(posedge clk_i);
    chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t5_word1", bram[1], 32'h1357_9BDF);
    chk("t5_word9", bram[9], 32'h5A5A_5A5A);

    // 6: reset after five fill writes
    d0 = done_cnt;
    pulse_clear(32'hDEAD_BEEF);
    repeat (5) @(posedge clk_i);
    #1 arst_ni = 0;
    @(negedge clk_i);
    chk("t6_busy", 32'(clear_busy_o), 32'h0);
    chk("t6_we", 32'(bram_we_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #1 arst_ni = 1;
    repeat (20) @(posedge clk_i);
    chk("t6_word4", bram[4], 32'hDEAD_BEEF);
    chk("t6_word1", bram[1], 32'hDEAD_BEEF);
    chk("t6_word5", bram[5], 32'h5A5A_5A5A);
    chk("t6_done_pulses", 32'(done_cnt - d0), 32'd0);

    // randomized traffic with asynchronous fill requests
    fork
      for (int k = 0; k < 80; k++) begin
        logic [31:0] a;
        a = $urandom_range(0, 32'h4F);
        if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
        apb($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), rd, er, ws);
      end
      repeat (5) begin
        repeat ($urandom_range(10, 60)) @(posedge clk_i);
        pulse_clear($urandom);
      end
    join
    repeat (40) @(posedge clk_i);
    for (int i = 0; i < DEPTH; i++) chk("final_mem", bram[i], exp_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
